fp_add_arbiter: RTL

- Round-robin scheduler that shares one multi-cycle floating-point adder (start/done handshake, 32-bit IEEE-754 single operands A, B and result Ans) between NREQ requesters.
- Grants one requester and latches its operands, then pulses the adder start and waits for done.
- Returns the adder result to the granted requester with a one-cycle response strobe.
- Sits between requesting engines and the adder's start/A/B/done/Ans ports.

---
 rtl/fp_add_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin arbiter sharing one multi-cycle FP adder among NREQ requesters.
// Define FPA_TIMEOUT_EN to add a WAIT-state watchdog that answers with a quiet NaN.
module fp_add_arbiter #(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   a_in,
  input  logic [32*NREQ-1:0]   b_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_data,
  output logic                 busy,
  output logic                 fpa_start,
  output logic [31:0]          fpa_a,
  output logic [31:0]          fpa_b,
  input  logic                 fpa_done,
  input  logic [31:0]          fpa_ans,
  output logic                 timeout_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t            r_state, w_next;
  logic [IW-1:0]     r_ptr, r_win, w_win;
  logic [IW:0]       w_idx;
  logic              w_found;
  logic              r_first;
  logic              w_done_q, w_tmo;
  logic [31:0]       w_a_arr [NREQ];
  logic [31:0]       w_b_arr [NREQ];
  logic [NREQ-1:0]   r_gnt, r_rsp_valid, w_gnt_d, w_rsp_valid_d;
  logic [31:0]       r_rsp_data, r_fpa_a, r_fpa_b;
  logic              r_busy, r_start, r_terr, w_busy_d, w_start_d;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_a_arr[i] = a_in[32*i +: 32];
      w_b_arr[i] = b_in[32*i +: 32];
    end
  end

  // First set bit strictly after the pointer, wrapping modulo NREQ.
  always_comb begin
    w_win   = r_ptr;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_idx >= (IW+1)'(NREQ)) w_idx = w_idx - (IW+1)'(NREQ);
      if (!w_found && req[w_idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IW-1:0];
      end
    end
  end

  // The first WAIT cycle masks a done level left over from the previous op.
  assign w_done_q = (r_state == S_WAIT) && !r_first && fpa_done;

`ifdef FPA_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        r_cnt <= '0;
    else if (r_state == S_LAUNCH)    r_cnt <= '0;
    else if (r_state == S_WAIT)      r_cnt <= r_cnt + CW'(1);
  end

  assign w_tmo = (r_state == S_WAIT) && !w_done_q && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (|req) w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT:   if (w_done_q || w_tmo) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_gnt_d       = (r_state == S_IDLE && |req) ? (ONE << w_win) : '0;
    w_start_d     = (r_state == S_IDLE) && (|req);
    w_rsp_valid_d = (r_state == S_WAIT && (w_done_q || w_tmo)) ? (ONE << r_win) : '0;
    w_busy_d      = (w_next != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr       <= IW'(NREQ - 1);
      r_win       <= '0;
      r_first     <= 1'b0;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_fpa_a     <= '0;
      r_fpa_b     <= '0;
      r_busy      <= 1'b0;
      r_start     <= 1'b0;
      r_terr      <= 1'b0;
    end else begin
      r_first     <= (r_state == S_LAUNCH);
      r_gnt       <= w_gnt_d;
      r_start     <= w_start_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_busy      <= w_busy_d;
      r_terr      <= w_tmo;
      if (r_state == S_IDLE && |req) begin
        r_win   <= w_win;
        r_fpa_a <= w_a_arr[w_win];
        r_fpa_b <= w_b_arr[w_win];
      end
      if (w_done_q)   r_rsp_data <= fpa_ans;
      else if (w_tmo) r_rsp_data <= QNAN;
      if (r_state == S_RESP) r_ptr <= r_win;
    end
  end

  assign gnt         = r_gnt;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign busy        = r_busy;
  assign fpa_start   = r_start;
  assign fpa_a       = r_fpa_a;
  assign fpa_b       = r_fpa_b;
  assign timeout_err = r_terr;

endmodule
